brushless_comm_ctrl: RTL and testbench

BRUSHLESS_COMM_CTRL -- requirements
Module: brushless_comm_ctrl

---
 rtl/brushless_comm_ctrl.sv | 153 +++++++++++++++
 tb/tb_brushless_comm_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/brushless_comm_ctrl.sv
// brushless_comm_ctrl
//   Six-step commutation controller for a brushless motor. The hall sensor
//   inputs are synchronized and then sampled once per PWM period. A four-state
//   FSM (IDLE/RUN/BRAKE/FAULT) chooses the coil drive selects and the duty
//   command.
//
//   Ports:
//     clk                       rising-edge clock
//     rst                       synchronous, active-high reset
//     go                        run enable
//     brake                     regenerative brake request
//     hallGrn/hallYlw/hallBlu   asynchronous hall sensor inputs
//     PWM_synch                 one-cycle pulse per PWM period
//     drv_mag[11:0]             requested drive magnitude (duty target = [11:1])
//     selGrn/selYlw/selBlu      coil select: 00 hi-Z, 01 rev, 10 fwd, 11 brake
//     duty[10:0]                duty command
//     hall_fault                high while in FAULT
//     comm_cnt[15:0]            saturating commutation count, cleared in IDLE
//
//   Build option: define DUTY_SLEW_EN to limit each RUN duty change to
//   SLEW_STEP per PWM period. Without it, the target is loaded directly.
module brushless_comm_ctrl #(
    parameter logic [10:0] BRAKE_DUTY = 11'h600,
    parameter logic [10:0] SLEW_STEP  = 11'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        brake,
    input  logic        hallGrn,
    input  logic        hallYlw,
    input  logic        hallBlu,
    input  logic        PWM_synch,
    input  logic [11:0] drv_mag,
    output logic [1:0]  selGrn,
    output logic [1:0]  selYlw,
    output logic [1:0]  selBlu,
    output logic [10:0] duty,
    output logic        hall_fault,
    output logic [15:0] comm_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, BRAKE, FAULT} state_t;

    // An all-ones step limit makes the slew limiter load the target directly.
`ifdef DUTY_SLEW_EN
    localparam logic [10:0] STEP_LIM = SLEW_STEP;
`else
    localparam logic [10:0] STEP_LIM = SLEW_STEP | 11'h7FF;
`endif

    state_t      state, state_nxt;
    logic [2:0]  hall_s1, hall_s2, hall_q, hall_q_nxt;
    logic [10:0] duty_nxt, target;
    logic [5:0]  sel_nxt;
    logic        h_valid;
    logic        unused_drv_lsb;

    assign unused_drv_lsb = drv_mag[0];
    assign target         = drv_mag[11:1];
    assign h_valid        = (hall_s2 != 3'b000) && (hall_s2 != 3'b111);
    assign hall_q_nxt     = PWM_synch ? hall_s2 : hall_q;
    assign hall_fault     = (state == FAULT);

    function automatic logic [5:0] sel_map(input logic [2:0] h);
        case (h)
            3'b101:  sel_map = 6'b10_01_00;
            3'b100:  sel_map = 6'b10_00_01;
            3'b110:  sel_map = 6'b00_10_01;
            3'b010:  sel_map = 6'b01_10_00;
            3'b011:  sel_map = 6'b01_00_10;
            3'b001:  sel_map = 6'b00_01_10;
            default: sel_map = 6'b00_00_00;
        endcase
    endfunction

    function automatic logic [10:0] slew(input logic [10:0] cur, input logic [10:0] tgt);
        if (tgt > cur)
            slew = ((tgt - cur) > STEP_LIM) ? cur + STEP_LIM : tgt;
        else
            slew = ((cur - tgt) > STEP_LIM) ? cur - STEP_LIM : tgt;
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (go && PWM_synch) state_nxt = h_valid ? RUN : FAULT;
            RUN: begin
                if (!go)
                    state_nxt = IDLE;
                else if (PWM_synch) begin
                    if (!h_valid)   state_nxt = FAULT;
                    else if (brake) state_nxt = BRAKE;
                end
            end
            BRAKE: begin
                if (!go)
                    state_nxt = IDLE;
                else if (PWM_synch && !brake)
                    state_nxt = h_valid ? RUN : FAULT;
            end
            FAULT: if (!go) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are computed from the next state so that they register
    // together with the state change.
    always_comb begin
        sel_nxt  = 6'b00_00_00;
        duty_nxt = duty;
        case (state_nxt)
            RUN: begin
                sel_nxt = sel_map(hall_q_nxt);
                if (PWM_synch) duty_nxt = slew(duty, target);
            end
            BRAKE: begin
                sel_nxt  = 6'b11_11_11;
                duty_nxt = BRAKE_DUTY;
            end
            default: duty_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hall_s1  <= '0;
            hall_s2  <= '0;
            hall_q   <= '0;
            selGrn   <= '0;
            selYlw   <= '0;
            selBlu   <= '0;
            duty     <= '0;
            comm_cnt <= '0;
        end else begin
            state   <= state_nxt;
            hall_s1 <= {hallGrn, hallYlw, hallBlu};
            hall_s2 <= hall_s1;
            hall_q  <= hall_q_nxt;
            {selGrn, selYlw, selBlu} <= sel_nxt;
            duty    <= duty_nxt;
            // hall_q is always a valid pattern while in RUN, so comparing
            // against it compares against the previous valid capture.
            if (state_nxt == IDLE)
                comm_cnt <= '0;
            else if (state == RUN && PWM_synch && h_valid &&
                     hall_s2 != hall_q && comm_cnt != 16'hFFFF)
                comm_cnt <= comm_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_brushless_comm_ctrl.sv
module tb_brushless_comm_ctrl;

    logic        clk = 1'b0;
    logic        rst, go, brake, hallGrn, hallYlw, hallBlu, PWM_synch;
    logic [11:0] drv_mag;
    logic [1:0]  selGrn, selYlw, selBlu;
    logic [10:0] duty;
    logic        hall_fault;
    logic [15:0] comm_cnt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    brushless_comm_ctrl #(.BRAKE_DUTY(11'h600), .SLEW_STEP(11'd8)) dut (
        .clk(clk), .rst(rst), .go(go), .brake(brake),
        .hallGrn(hallGrn), .hallYlw(hallYlw), .hallBlu(hallBlu),
        .PWM_synch(PWM_synch), .drv_mag(drv_mag),
        .selGrn(selGrn), .selYlw(selYlw), .selBlu(selBlu),
        .duty(duty), .hall_fault(hall_fault), .comm_cnt(comm_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive hall inputs and let them settle through the synchronizer.
    task automatic set_hall(input logic [2:0] h);
        {hallGrn, hallYlw, hallBlu} = h;
        repeat (3) tick();
    endtask

    task automatic pulse();
        PWM_synch = 1'b1;
        tick();
        PWM_synch = 1'b0;
    endtask

    function automatic logic [5:0] exp_sel(input logic [2:0] h);
        case (h)
            3'b101:  return 6'b10_01_00;
            3'b100:  return 6'b10_00_01;
            3'b110:  return 6'b00_10_01;
            3'b010:  return 6'b01_10_00;
            3'b011:  return 6'b01_00_10;
            3'b001:  return 6'b00_01_10;
            default: return 6'b00_00_00;
        endcase
    endfunction

    logic [2:0] seq [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

    initial begin
        rst = 1'b1; go = 1'b0; brake = 1'b0; PWM_synch = 1'b0;
        drv_mag = 12'h000; {hallGrn, hallYlw, hallBlu} = 3'b000;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst_sel", {10'h0, selGrn, selYlw, selBlu}, 16'h0);
        check("rst_duty", {5'h0, duty}, 16'h0);
        check("rst_fault", {15'h0, hall_fault}, 16'h0);
        check("rst_cnt", comm_cnt, 16'h0);

        // go without a PWM pulse stays IDLE
        go = 1'b1;
        set_hall(3'b101);
        check("idle_nopulse_sel", {10'h0, selGrn, selYlw, selBlu}, 16'h0);

        // Enter RUN on H=101
        pulse();
        check("run_entry_sel", {10'h0, selGrn, selYlw, selBlu}, {10'h0, 6'b10_01_00});
        check("run_entry_cnt", comm_cnt, 16'h0);

        // Six-step sequence
        for (int unsigned i = 0; i < 6; i++) begin
            set_hall(seq[i]);
            check("step_sel_pre", {10'h0, selGrn, selYlw, selBlu}, {10'h0, exp_sel(i == 0 ? 3'b101 : seq[i-1])});
            pulse();
            check("step_sel", {10'h0, selGrn, selYlw, selBlu}, {10'h0, exp_sel(seq[i])});
        end
        check("step_cnt6", comm_cnt, 16'd6);
        // Same H captured again: no commutation
        pulse();
        check("repeat_cnt", comm_cnt, 16'd6);

        // Duty response
        drv_mag = 12'hFFF;
        repeat (2) tick();
        check("duty_no_pulse", {5'h0, duty}, 16'h0);
`ifdef DUTY_SLEW_EN
        pulse();
        check("slew_1", {5'h0, duty}, 16'd8);
        pulse();
        check("slew_2", {5'h0, duty}, 16'd16);
        repeat (253) pulse();
        check("slew_255", {5'h0, duty}, 16'd2040);
        pulse();
        check("slew_256", {5'h0, duty}, 16'h7FF);
        pulse();
        check("slew_hold", {5'h0, duty}, 16'h7FF);
`else
        pulse();
        check("direct_1", {5'h0, duty}, 16'h7FF);
        pulse();
        check("direct_hold", {5'h0, duty}, 16'h7FF);
`endif

        // Brake: request without pulse has no effect
        brake = 1'b1;
        repeat (2) tick();
        check("brake_nopulse", {10'h0, selGrn, selYlw, selBlu}, {10'h0, 6'b10_01_00});
        pulse();
        check("brake_sel", {10'h0, selGrn, selYlw, selBlu}, {10'h0, 6'b11_11_11});
        check("brake_duty", {5'h0, duty}, 16'h600);
        brake = 1'b0;
        pulse();
        check("resume_sel", {10'h0, selGrn, selYlw, selBlu}, {10'h0, 6'b10_01_00});
`ifdef DUTY_SLEW_EN
        check("resume_duty", {5'h0, duty}, 16'h608);
`else
        check("resume_duty", {5'h0, duty}, 16'h7FF);
`endif

        // Invalid hall pattern has priority over brake
        brake = 1'b1;
        set_hall(3'b111);
        pulse();
        brake = 1'b0;
        check("fault_flag", {15'h0, hall_fault}, 16'h1);
        check("fault_sel", {10'h0, selGrn, selYlw, selBlu}, 16'h0);
        check("fault_duty", {5'h0, duty}, 16'h0);
        set_hall(3'b101);
        repeat (2) pulse();
        check("fault_sticky", {15'h0, hall_fault}, 16'h1);
        go = 1'b0;
        tick();
        check("fault_exit", {15'h0, hall_fault}, 16'h0);
        check("fault_exit_cnt", comm_cnt, 16'h0);

        // IDLE with H=000 -> FAULT
        go = 1'b1;
        set_hall(3'b000);
        pulse();
        check("idle_to_fault", {15'h0, hall_fault}, 16'h1);
        go = 1'b0;
        tick();

        // Five commutations, then reset mid-RUN
        go = 1'b1;
        set_hall(3'b101);
        pulse();
        for (int unsigned i = 0; i < 5; i++) begin
            set_hall(seq[i]);
            pulse();
        end
        check("cnt5", comm_cnt, 16'd5);
        check("cnt5_sel", {10'h0, selGrn, selYlw, selBlu}, {10'h0, exp_sel(seq[4])});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_sel", {10'h0, selGrn, selYlw, selBlu}, 16'h0);
        check("midrst_duty", {5'h0, duty}, 16'h0);
        check("midrst_cnt", comm_cnt, 16'h0);

        // go=0 in RUN returns to IDLE without a pulse
        set_hall(3'b101);
        pulse();
        check("rerun_sel", {10'h0, selGrn, selYlw, selBlu}, {10'h0, 6'b10_01_00});
        go = 1'b0;
        tick();
        check("goff_sel", {10'h0, selGrn, selYlw, selBlu}, 16'h0);
        check("goff_duty", {5'h0, duty}, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
